// File: rtl/crane_pkg.sv
// Shared crane definitions: FSM state codes, button indices, default travel
// limits (also used by the display logic) and a timer sizing helper.
package crane_pkg;

    // Default travel limits of the production machine.
    localparam int X_MAX_DEFAULT = 15;
    localparam int Y_MAX_DEFAULT = 15;
    localparam int Z_MAX_DEFAULT = 7;

    // Claw FSM states, 3-bit binary encoding.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOWER   = 3'd1,
        ST_GRAB    = 3'd2,
        ST_RAISE   = 3'd3,
        ST_RETURN  = 3'd4,
        ST_RELEASE = 3'd5
    } crane_state_t;

    // Bit positions of the buttons in the internal button vectors.
    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_FWD   = 2;
    localparam int BTN_BACK  = 3;
    localparam int BTN_DROP  = 4;
    localparam int NUM_BTN   = 5;

    // Width of the shared step/dwell timer: must hold max(step, grab) - 1.
    function automatic int timer_width(input int step_cycles, input int grab_cycles);
        int longest;
        longest = (step_cycles > grab_cycles) ? step_cycles : grab_cycles;
        return (longest < 2) ? 1 : $clog2(longest);
    endfunction

endpackage

// File: rtl/crane_ctrl_fsm_btn_edge_sync.sv
// Two-flop synchroniser plus rising-edge detector for one debounced button.
// Produces a one-clock event per press; a button already held when reset is
// released produces no event.
module btn_edge_sync (
    input  logic clock,
    input  logic reset,
    input  logic level_in,
    output logic event_out
);

    logic       sync1_q;
    logic       sync2_q;
    logic       prev_q;
    logic [1:0] arm_q;

    // Synchronise the level, keep its previous value, and count out the
    // pipeline fill after reset. Until the chain has settled, prev_q simply
    // follows sync2_q, so a level that was already high at reset release is
    // seen as "held" rather than as a fresh press.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            arm_q   <= 2'd0;
        end else begin
            sync1_q <= level_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (arm_q != 2'd3) begin
                arm_q <= arm_q + 2'd1;
            end
        end
    end

    assign event_out = (arm_q == 2'd3) && sync2_q && !prev_q;

endmodule

// File: rtl/crane_ctrl_fsm.sv
// Crane claw controller: per-button edge events drive manual X/Y jogging in
// IDLE; a drop event runs the automatic lower/grab/raise/return/release
// sequence using one shared step/dwell timer.
module crane_ctrl_fsm
    import crane_pkg::*;
#(
    parameter int X_MAX       = X_MAX_DEFAULT,
    parameter int Y_MAX       = Y_MAX_DEFAULT,
    parameter int Z_MAX       = Z_MAX_DEFAULT,
    parameter int STEP_CYCLES = 5000000,
    parameter int GRAB_CYCLES = 50000000
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         btn_left,
    input  logic                         btn_right,
    input  logic                         btn_fwd,
    input  logic                         btn_back,
    input  logic                         btn_drop,
    output logic [$clog2(X_MAX+1)-1:0]   pos_x,
    output logic [$clog2(Y_MAX+1)-1:0]   pos_y,
    output logic [$clog2(Z_MAX+1)-1:0]   pos_z,
    output logic                         claw_closed,
    output logic                         busy,
    output logic                         drop_done
);

    localparam int XW = $clog2(X_MAX + 1);
    localparam int YW = $clog2(Y_MAX + 1);
    localparam int ZW = $clog2(Z_MAX + 1);
    localparam int TW = timer_width(STEP_CYCLES, GRAB_CYCLES);

    localparam logic [XW-1:0] X_TOP     = XW'(X_MAX);
    localparam logic [YW-1:0] Y_TOP     = YW'(Y_MAX);
    localparam logic [ZW-1:0] Z_LAST    = ZW'(Z_MAX - 1);
    localparam logic [TW-1:0] STEP_LAST = TW'(STEP_CYCLES - 1);
    localparam logic [TW-1:0] GRAB_LAST = TW'(GRAB_CYCLES - 1);

    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_evt;

    crane_state_t  state_q;
    logic [TW-1:0] timer_q;
    logic [XW-1:0] pos_x_q;
    logic [YW-1:0] pos_y_q;
    logic [ZW-1:0] pos_z_q;
    logic          claw_q;
    logic          busy_q;
    logic          done_q;

    assign btn_level[BTN_LEFT]  = btn_left;
    assign btn_level[BTN_RIGHT] = btn_right;
    assign btn_level[BTN_FWD]   = btn_fwd;
    assign btn_level[BTN_BACK]  = btn_back;
    assign btn_level[BTN_DROP]  = btn_drop;

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_edge_sync u_btn_edge_sync (
                .clock     (clock),
                .reset     (reset),
                .level_in  (btn_level[gi]),
                .event_out (btn_evt[gi])
            );
        end
    endgenerate

    // Jog decisions: opposing presses cancel, limits saturate.
    logic x_up, x_dn, y_up, y_dn, step_end, grab_end;
    assign x_up = btn_evt[BTN_RIGHT] && !btn_evt[BTN_LEFT]  && (pos_x_q != X_TOP);
    assign x_dn = btn_evt[BTN_LEFT]  && !btn_evt[BTN_RIGHT] && (pos_x_q != '0);
    assign y_up = btn_evt[BTN_FWD]   && !btn_evt[BTN_BACK]  && (pos_y_q != Y_TOP);
    assign y_dn = btn_evt[BTN_BACK]  && !btn_evt[BTN_FWD]   && (pos_y_q != '0);
    assign step_end = (timer_q == STEP_LAST);
    assign grab_end = (timer_q == GRAB_LAST);

    // Claw FSM with position registers, shared timer and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            pos_x_q <= '0;
            pos_y_q <= '0;
            pos_z_q <= '0;
            claw_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    timer_q <= '0;
                    if (btn_evt[BTN_DROP]) begin
                        // Drop takes priority; same-clock jog events are lost.
                        state_q <= ST_LOWER;
                        busy_q  <= 1'b1;
                    end else begin
                        if (x_up) pos_x_q <= pos_x_q + 1'b1;
                        else if (x_dn) pos_x_q <= pos_x_q - 1'b1;
                        if (y_up) pos_y_q <= pos_y_q + 1'b1;
                        else if (y_dn) pos_y_q <= pos_y_q - 1'b1;
                    end
                end
                ST_LOWER: begin
                    if (step_end) begin
                        timer_q <= '0;
                        pos_z_q <= pos_z_q + 1'b1;
                        if (pos_z_q == Z_LAST) begin
                            state_q <= ST_GRAB;
                            claw_q  <= 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ST_GRAB: begin
                    if (grab_end) begin
                        timer_q <= '0;
                        state_q <= ST_RAISE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ST_RAISE: begin
                    if (step_end) begin
                        timer_q <= '0;
                        pos_z_q <= pos_z_q - 1'b1;
                        if (pos_z_q == ZW'(1)) begin
                            state_q <= ST_RETURN;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ST_RETURN: begin
                    // Home check comes first, so a drop from the origin
                    // spends a single clock here.
                    if ((pos_x_q == '0) && (pos_y_q == '0)) begin
                        timer_q <= '0;
                        state_q <= ST_RELEASE;
                        claw_q  <= 1'b0;
                    end else if (step_end) begin
                        timer_q <= '0;
                        if (pos_x_q != '0) pos_x_q <= pos_x_q - 1'b1;
                        else pos_y_q <= pos_y_q - 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (grab_end) begin
                        timer_q <= '0;
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: begin
                    // Unused encodings recover to IDLE.
                    timer_q <= '0;
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    claw_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pos_x       = pos_x_q;
    assign pos_y       = pos_y_q;
    assign pos_z       = pos_z_q;
    assign claw_closed = claw_q;
    assign busy        = busy_q;
    assign drop_done   = done_q;

endmodule
